// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    // 'release' is a reserved word, so the break flag is called rel.
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ps2_evt_t;

    localparam int unsigned PS2_EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_rx_fifo.sv
// 4-entry key event FIFO; compiled only when PS2_RX_FIFO_EN is defined.
`ifdef PS2_RX_FIFO_EN
module ps2_rx_fifo
    import ps2_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [PS2_EVT_W-1:0] data_i,
    input  logic                 pop_i,
    output logic [PS2_EVT_W-1:0] data_o,
    output logic                 empty_o,
    output logic                 full_o
);

    logic [PS2_EVT_W-1:0] mem_q [4];
    logic [1:0]           wr_ptr_q, rd_ptr_q;
    logic [2:0]           cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == 3'd0);
    assign full_o  = (cnt_q == 3'd4);

endmodule
`endif

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filtered clock, frame decode, E0/F0 prefix folding.
// Optional event FIFO enabled by defining PS2_RX_FIFO_EN.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_rd,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_strobe,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       rx_busy
);

    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, fall_q;
    logic [FW-1:0] filt_cnt_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            fall_q     <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
                fall_q     <= filt_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    ps2_state_e    state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q, ext_q, rel_q;
    logic [TW-1:0] to_cnt_q;
    logic          frame_err_q, parity_err_q;

    logic     data_s, stop_eval, stop_bad, par_bad, byte_ok, start_bad;
    logic     is_ext, is_brk, evt_push;
    ps2_evt_t evt_d;

    assign data_s    = dat_sync_q[1];
    assign stop_eval = fall_q && (state_q == STOP);
    assign stop_bad  = stop_eval && !data_s;
    assign par_bad   = stop_eval && data_s && !(^{shift_q, par_q});
    assign byte_ok   = stop_eval && data_s && (^{shift_q, par_q});
    assign start_bad = fall_q && (state_q == IDLE) && data_s;
    assign is_ext    = (shift_q == PS2_PREFIX_EXT);
    assign is_brk    = (shift_q == PS2_PREFIX_BRK);
    assign evt_push  = byte_ok && !is_ext && !is_brk;
    assign evt_d     = '{code: shift_q, ext: ext_q, rel: rel_q};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            to_cnt_q     <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= start_bad || stop_bad;
            parity_err_q <= par_bad;
            to_cnt_q     <= (state_q == IDLE || fall_q) ? '0 : to_cnt_q + 1'b1;
            // A stalled frame is dropped silently; prefix flags survive.
            if (state_q != IDLE && !fall_q && to_cnt_q == TW'(TIMEOUT - 1)) begin
                state_q <= IDLE;
            end else if (fall_q) begin
                unique case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= data_s;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!byte_ok) begin
                            ext_q <= 1'b0;
                            rel_q <= 1'b0;
                        end else if (is_ext) begin
                            ext_q <= 1'b1;
                        end else if (is_brk) begin
                            rel_q <= 1'b1;
                        end else begin
                            ext_q <= 1'b0;
                            rel_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign rx_busy    = (state_q != IDLE);

    logic strobe_q;
    assign key_strobe = strobe_q;

`ifdef PS2_RX_FIFO_EN
    ps2_evt_t head;
    logic     empty, full, pop, push_ok, overflow_q;

    assign pop     = key_rd && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = evt_push && (!full || pop);

    ps2_rx_fifo u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (push_ok),
        .data_i  (evt_d),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            strobe_q   <= push_ok;
            overflow_q <= evt_push && !push_ok;
        end
    end

    assign key_code    = head.code;
    assign key_ext     = head.ext;
    assign key_release = head.rel;
    assign key_valid   = !empty;
    assign overflow    = overflow_q;
`else
    ps2_evt_t evt_q;
    logic     valid_q;
    logic     unused_key_rd;

    assign unused_key_rd = key_rd;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            evt_q    <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= evt_push;
            if (evt_push) begin
                evt_q   <= evt_d;
                valid_q <= 1'b1;
            end
        end
    end

    assign key_code    = evt_q.code;
    assign key_ext     = evt_q.ext;
    assign key_release = evt_q.rel;
    assign key_valid   = valid_q;
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx; define PS2_RX_FIFO_EN to cover the FIFO build.
module tb_ps2_kbd_rx;

    localparam int FILT_LEN = 4;
    localparam int TIMEOUT  = 4096;
    localparam int H        = 20;  // clk_sys cycles per PS/2 clock half-period

    logic       clk_sys = 1'b0;
    logic       reset, ps2_clk, ps2_data, key_rd;
    logic [7:0] key_code;
    logic       key_ext, key_release, key_strobe, key_valid;
    logic       parity_err, frame_err, overflow, rx_busy;

    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0, par_cnt = 0, frm_cnt = 0, ovf_cnt = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    ps2_kbd_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_rd      (key_rd),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_strobe  (key_strobe),
        .key_valid   (key_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .rx_busy     (rx_busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (key_strobe) begin
                strobe_cnt++;
`ifndef PS2_RX_FIFO_EN
                obs_q.push_back({key_code, key_ext, key_release});
`endif
            end
            if (parity_err) par_cnt++;
            if (frame_err)  frm_cnt++;
            if (overflow)   ovf_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic pflip,
                                             input logic stop);
        return {stop, ~(^b) ^ pflip, b, 1'b0};
    endfunction

    function automatic logic [9:0] mk_evt(input logic [7:0] c, input logic e, input logic r);
        return {c, e, r};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0, 1'b1), 11);
    endtask

    // Moves FIFO entries into obs_q; events are collected on strobe otherwise.
    task automatic drain_events();
`ifdef PS2_RX_FIFO_EN
        for (int i = 0; i < 8 && key_valid; i++) begin
            obs_q.push_back({key_code, key_ext, key_release});
            key_rd = 1'b1;
            wait_cyc(1);
            key_rd = 1'b0;
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; key_rd = 1'b0;
        wait_cyc(5);
        vectors++;
        if ({key_code, key_ext, key_release, key_strobe, key_valid} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_event: got %h %b%b%b%b, want 0", key_code, key_ext,
                     key_release, key_strobe, key_valid);
        end
        vectors++;
        if ({parity_err, frame_err, overflow, rx_busy} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 0000",
                     {parity_err, frame_err, overflow, rx_busy});
        end
        reset = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_single_key();
        logic [10:0] f;
        logic [9:0]  e, g;
        int lat;
        f = mk_frame(8'h1C, 1'b0, 1'b1);
        exp_q.push_back(mk_evt(8'h1C, 1'b0, 1'b0));
        send_bits(f, 10);
        ps2_data = f[10];
        wait_cyc(H);
        ps2_clk = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            wait_cyc(1);
            if (key_strobe === 1'b1 && lat < 0) lat = k;
        end
        wait_cyc(H);
        ps2_clk = 1'b1;
        wait_cyc(H);
        vectors++;
        if (lat != FILT_LEN + 3) begin
            miscompares++;
            $display("FAIL strobe_latency: got %0d, want %0d", lat, FILT_LEN + 3);
        end
        drain_events();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL single_evt: got none, want %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL single_evt: got %h, want %h", g, e);
                end
            end
        end
    endtask

    task automatic test_prefix();
        logic [9:0] e, g;
        int s0;
        s0 = strobe_cnt;
        exp_q.push_back(mk_evt(8'h75, 1'b1, 1'b1));
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        vectors++;
        if (strobe_cnt - s0 != 1) begin
            miscompares++;
            $display("FAIL prefix_strobes: got %0d, want 1", strobe_cnt - s0);
        end
        exp_q.push_back(mk_evt(8'h29, 1'b0, 1'b0));
        send_byte(8'h29);
        drain_events();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL prefix_evt: got none, want %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL prefix_evt: got %h, want %h", g, e);
                end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL prefix_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_errors();
        logic [9:0] e, g;
        int s0, p0, f0;
        s0 = strobe_cnt; p0 = par_cnt; f0 = frm_cnt;
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
        vectors++;
        if (par_cnt - p0 != 1 || strobe_cnt != s0) begin
            miscompares++;
            $display("FAIL parity_err: got perr %0d strobes %0d, want 1 0",
                     par_cnt - p0, strobe_cnt - s0);
        end
        send_bits(mk_frame(8'hF0, 1'b0, 1'b0), 11);
        vectors++;
        if (frm_cnt - f0 != 1) begin
            miscompares++;
            $display("FAIL stop_err: got %0d, want 1", frm_cnt - f0);
        end
        send_bits(11'h7FF, 1);
        vectors++;
        if (frm_cnt - f0 != 2 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_err: got ferr %0d busy %b, want 2 0", frm_cnt - f0, rx_busy);
        end
        exp_q.push_back(mk_evt(8'h1C, 1'b0, 1'b0));
        send_byte(8'h1C);
        drain_events();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL err_evt: got none, want %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL err_evt: got %h, want %h", g, e);
                end
            end
        end
    endtask

    task automatic test_glitch_timeout();
        logic [9:0] e, g;
        int p0, f0;
        p0 = par_cnt; f0 = frm_cnt;
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(20);
        vectors++;
        if (frm_cnt != f0 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch: got ferr %0d busy %b, want 0 0", frm_cnt - f0, rx_busy);
        end
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 6);
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_busy: got %b, want 1", rx_busy);
        end
        wait_cyc(TIMEOUT + 10);
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_idle: got %b, want 0", rx_busy);
        end
        exp_q.push_back(mk_evt(8'h29, 1'b0, 1'b0));
        send_byte(8'h29);
        vectors++;
        if (par_cnt != p0 || frm_cnt != f0) begin
            miscompares++;
            $display("FAIL timeout_errs: got perr %0d ferr %0d, want 0 0",
                     par_cnt - p0, frm_cnt - f0);
        end
        drain_events();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL timeout_evt: got none, want %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL timeout_evt: got %h, want %h", g, e);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] e, g;
        int s0;
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5);
        reset = 1'b1;
        wait_cyc(3);
        vectors++;
        if ({key_code, key_ext, key_release, key_strobe, key_valid, rx_busy} !== 13'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h %b%b%b%b%b, want 0", key_code, key_ext,
                     key_release, key_strobe, key_valid, rx_busy);
        end
        reset = 1'b0;
        s0 = strobe_cnt;
        wait_cyc(100);
        vectors++;
        if (strobe_cnt != s0 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got strobes %0d busy %b, want 0 0",
                     strobe_cnt - s0, rx_busy);
        end
        exp_q.push_back(mk_evt(8'h5A, 1'b0, 1'b0));
        send_byte(8'h5A);
        drain_events();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL midreset_evt: got none, want %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL midreset_evt: got %h, want %h", g, e);
                end
            end
        end
    endtask

`ifdef PS2_RX_FIFO_EN
    task automatic test_fifo();
        logic [7:0] codes [5];
        logic [9:0] e, g;
        int s0, o0;
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        s0 = strobe_cnt; o0 = ovf_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_evt(codes[i], 1'b0, 1'b0));
            send_byte(codes[i]);
        end
        vectors++;
        if (ovf_cnt != o0 || strobe_cnt - s0 != 4) begin
            miscompares++;
            $display("FAIL fifo_fill: got ovf %0d strobes %0d, want 0 4",
                     ovf_cnt - o0, strobe_cnt - s0);
        end
        send_byte(codes[4]);
        vectors++;
        if (ovf_cnt - o0 != 1 || strobe_cnt - s0 != 4) begin
            miscompares++;
            $display("FAIL fifo_overflow: got ovf %0d strobes %0d, want 1 4",
                     ovf_cnt - o0, strobe_cnt - s0);
        end
        drain_events();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL fifo_evt: got none, want %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL fifo_evt: got %h, want %h", g, e);
                end
            end
        end
        vectors++;
        if (key_valid !== 1'b0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL fifo_empty: got valid %b extra %0d, want 0 0",
                     key_valid, obs_q.size());
        end
    endtask
`else
    task automatic test_no_fifo();
        key_rd = 1'b1;
        wait_cyc(3);
        key_rd = 1'b0;
        wait_cyc(1);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 8'h5A || ovf_cnt != 0) begin
            miscompares++;
            $display("FAIL hold_last: got valid %b code %h ovf %0d, want 1 5a 0",
                     key_valid, key_code, ovf_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_key();
        test_prefix();
        test_errors();
        test_glitch_timeout();
        test_reset_midframe();
`ifdef PS2_RX_FIFO_EN
        test_fifo();
`else
        test_no_fifo();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Core-side PS/2 keyboard receiver.
- Consumes the ps2_kbd_clk / ps2_kbd_data pair produced by the MiST IO block's PS/2 transmitter, or a real PS/2 port.
- Decodes 11-bit frames and folds E0/F0 prefix bytes into single key events with extended and release flags for the core's keyboard matrix logic.
- Runs entirely in clk_sys; the PS/2 inputs are treated as asynchronous.

Parameters:
FILT_LEN, 4, number of consecutive equal clk_sys samples needed to accept a new ps2_clk level (glitch filter)
TIMEOUT, 4096, clk_sys cycles without a ps2_clk falling edge after which a partial frame is discarded

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  PS/2 clock line (async)
ps2_data  in  1  PS/2 data line (async)
key_rd  in  1  pop one event; used only with PS2_RX_FIFO_EN
key_code  out  8  scancode of the current event
key_ext  out  1  event was preceded by E0
key_release  out  1  event was preceded by F0
key_strobe  out  1  one-cycle pulse when a new event becomes valid
key_valid  out  1  event available (FIFO not empty / register loaded)
parity_err  out  1  one-cycle pulse on odd-parity failure
frame_err  out  1  one-cycle pulse on start=1 or stop=0
overflow  out  1  one-cycle pulse when an event is dropped
rx_busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0; state IDLE; prefix flags cleared; bit counter 0; filter holds level 1; FIFO empty. Reset mid-frame abandons the frame, and nothing is emitted afterwards.
- Input path:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock changes level only after FILT_LEN identical synchronized samples.
  - Falling edge = filtered level 1 -> 0. ps2_data (synchronized) is sampled on that edge.
- FSM, advancing only on a falling edge:
  - IDLE: data=0 -> DATA, cnt=0. data=1 -> frame_err pulse, stay IDLE.
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: evaluate -> IDLE.
- Stop evaluation, in priority order:
  - stop=0 -> frame_err.
  - Else XOR of the 8 data bits and parity = 0 -> parity_err.
  - Else the byte is accepted.
  - Any error also clears both prefix flags.
- Byte decode:
  - E0 sets ext flag; F0 sets release flag; neither emits an event.
  - Any other byte, including E1, emits an event {code, ext, release}, then clears both flags.
  - E0 F0 in that order yields ext=1 and release=1.
- Timeout:
  - Counter reloads on every falling edge while state != IDLE.
  - Reaching TIMEOUT -> IDLE; the partial byte is discarded silently.
  - Prefix flags are kept.
- Latency:
  - Inputs are driven synchronously one clk_sys cycle after an edge.
  - key_strobe and error pulses assert exactly FILT_LEN+3 clk_sys cycles after the ps2_clk falling edge of the stop bit.
- Without FIFO:
  - key_code/key_ext/key_release hold the last event until the next one; key_valid is set on the first event and stays 1.
  - overflow is always 0; key_rd is ignored.
- Simultaneous pop and push (FIFO variant): both take effect in the same cycle and the count is unchanged.

Optional Feature:
- Macro PS2_RX_FIFO_EN.
- Defined:
  - Adds a 4-entry 10-bit event FIFO.
  - key_code/key_ext/key_release show the head entry; key_valid = not empty.
  - key_rd with key_valid pops; key_rd on empty is ignored.
  - Push when full drops the new event and pulses overflow.
  - key_strobe pulses on every successful push.
- Not defined: single output register as in Behaviour.

Decomposition:
- Package ps2_pkg holds:
  - PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0;
  - PS2_DATA_BITS=8;
  - FSM state enum {IDLE, DATA, PARITY, STOP};
  - event struct {code[7:0], ext, release}.
- Sub-module ps2_rx_fifo (4 x 10 bits, 2-bit pointers plus a count) is instantiated only under PS2_RX_FIFO_EN.

Test Plan:
- Frame 0x1C (data 00111000 LSB first, parity 0, stop 1) -> key_strobe once; key_code=1C, key_ext=0, key_release=0; strobe at FILT_LEN+3 cycles after the stop edge.
- Sequence E0, F0, 75 -> exactly one strobe; key_code=75, key_ext=1, key_release=1. Next frame 0x29 -> key_ext=0, key_release=0.
- 0x1C with parity=1 -> parity_err pulse, no strobe. Then F0 with stop=0 -> frame_err, and the following 0x1C reports key_release=0.
- Falling-edge glitch of 2 cycles on ps2_clk (FILT_LEN=4) -> no state change. Start bit + 5 bits, then TIMEOUT+10 idle cycles, then full 0x29 -> key_code=29, no error.
- Reset asserted after 4 data bits -> all outputs 0 during reset; after release, a full 0x5A frame -> key_code=5A.
- PS2_RX_FIFO_EN: 5 events 0x16, 0x1E, 0x26, 0x25, 0x2E with no key_rd -> overflow on the 5th. Popping yields 16, 1E, 26, 25, then key_valid=0.
